// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for a 4-digit, 7-segment display.
//
// Each digit is driven for SCAN_DIV cycles. With FND_BLANK_EN defined, an all-off gap of
// BLANK_CYC cycles follows every digit. New display data is staged by `load` and becomes
// active at the next frame boundary, or immediately while idle.
//
// Configuration macro:
//   FND_BLANK_EN  defined   -> IDLE/DRIVE/BLANK scan with an inter-digit blank gap
//                 undefined -> IDLE/DRIVE scan only; BLANK_CYC is ignored
//
// Ports:
//   ACLK        in   clock, rising edge
//   ARESETN     in   asynchronous active-low reset
//   enable      in   scanning runs while high
//   load        in   one-cycle request to stage disp_value/dp_mask/digit_en
//   disp_value  in   four hex nibbles; nibble k drives digit k
//   dp_mask     in   per-digit decimal point on
//   digit_en    in   per-digit enable; a disabled digit stays dark in its slot
//   load_ack    out  one-cycle pulse when staged data becomes active
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
//   an          out  digit anodes, active-low
//   frame_done  out  one-cycle pulse when the digit index wraps 3->0
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] disp_value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  digit_en,
    output logic        load_ack,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned     CntW    = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StBlank
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dig_q, dig_d;
    logic [CntW-1:0] cnt_q, cnt_d;

`ifdef FND_BLANK_EN
    localparam logic [7:0] BlankLast = 8'(BLANK_CYC - 1);
    logic [7:0] bcnt_q, bcnt_d;
`else
    logic unused_blank_cyc;
    assign unused_blank_cyc = ^BLANK_CYC;
`endif

    logic [15:0] pend_val_q, pend_val_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic [3:0]  pend_en_q, pend_en_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] act_val_q, act_val_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic [3:0]  act_en_q, act_en_d;

    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       load_ack_q, load_ack_d;
    logic       frame_done_q, frame_done_d;
    logic       wrap;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h7F;
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        dig_d      = dig_q;
        cnt_d      = cnt_q;
`ifdef FND_BLANK_EN
        bcnt_d     = bcnt_q;
`endif
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        pend_vld_d = pend_vld_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        load_ack_d = 1'b0;
        wrap       = 1'b0;

        // Last load before application wins
        if (load) begin
            pend_val_d = disp_value;
            pend_dp_d  = dp_mask;
            pend_en_d  = digit_en;
            pend_vld_d = 1'b1;
        end

        if (!enable) begin
            state_d = StIdle;
            dig_d   = '0;
            cnt_d   = '0;
`ifdef FND_BLANK_EN
            bcnt_d  = '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StDrive;
                    dig_d   = '0;
                    cnt_d   = '0;
                end
                StDrive: begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
`ifdef FND_BLANK_EN
                        state_d = StBlank;
                        bcnt_d  = '0;
`else
                        dig_d = dig_q + 2'd1;
                        wrap  = (dig_q == 2'd3);
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef FND_BLANK_EN
                StBlank: begin
                    if (bcnt_q == BlankLast) begin
                        bcnt_d  = '0;
                        state_d = StDrive;
                        dig_d   = dig_q + 2'd1;
                        wrap    = (dig_q == 2'd3);
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    dig_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_done_d = wrap;

        // Staged data goes live while idle or at the frame wrap; pend_*_d already includes a
        // load arriving in this very cycle.
        if ((state_q == StIdle || wrap) && pend_vld_d) begin
            act_val_d  = pend_val_d;
            act_dp_d   = pend_dp_d;
            act_en_d   = pend_en_d;
            pend_vld_d = 1'b0;
            load_ack_d = 1'b1;
        end

        // Outputs are computed from next-state values and registered, so they only move on
        // state/digit transitions.
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == StDrive && act_en_d[dig_d]) begin
            an_d[dig_d] = 1'b0;
            seg_d       = hex7(act_val_d[{dig_d, 2'b00} +: 4]);
            dp_d        = ~act_dp_d[dig_d];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            dig_q        <= '0;
            cnt_q        <= '0;
`ifdef FND_BLANK_EN
            bcnt_q       <= '0;
`endif
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_vld_q   <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_q        <= dig_d;
            cnt_q        <= cnt_d;
`ifdef FND_BLANK_EN
            bcnt_q       <= bcnt_d;
`endif
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_vld_q   <= pend_vld_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2. Expected slot timing follows the
// FND_BLANK_EN setting of the build.
module tb_fnd_scan_ctrl;

    localparam int SCAN = 4;
`ifdef FND_BLANK_EN
    localparam int SLOT = 6;
`else
    localparam int SLOT = 4;
`endif
    localparam int FRAME = 4 * SLOT;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        enable;
    logic        load;
    logic [15:0] disp_value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic        load_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Segment tables packed {slot3, slot2, slot1, slot0}
    logic [27:0] segs_a;
    logic [27:0] segs_b;
    logic [27:0] segs_c;
    logic [27:0] segs_d;

    fnd_scan_ctrl #(
        .SCAN_DIV (4),
        .BLANK_CYC(2)
    ) u_dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .enable    (enable),
        .load      (load),
        .disp_value(disp_value),
        .dp_mask   (dp_mask),
        .digit_en  (digit_en),
        .load_ack  (load_ack),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // c counts cycles from the first DRIVE cycle of digit 0
    task automatic scan_check(input int c, input logic [27:0] segs, input logic [3:0] en,
                              input logic [3:0] dpm, input logic ack_exp);
        int         p;
        int         slot;
        logic       lit;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        p     = c % FRAME;
        slot  = p / SLOT;
        lit   = ((p % SLOT) < SCAN) && en[slot];
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (lit) begin
            an_e  = ~(4'b0001 << slot);
            seg_e = segs[slot*7 +: 7];
            dp_e  = ~dpm[slot];
        end
        check_val($sformatf("an@%0d", c), 32'(an), 32'(an_e));
        check_val($sformatf("seg@%0d", c), 32'(seg), 32'(seg_e));
        check_val($sformatf("dp@%0d", c), 32'(dp), 32'(dp_e));
        check_val($sformatf("frame_done@%0d", c), 32'(frame_done),
                  32'((p == 0) && (c > 0)));
        check_val($sformatf("load_ack@%0d", c), 32'(load_ack), 32'(ack_exp));
    endtask

    task automatic check_dark(input string tag);
        check_val({tag, "_an"}, 32'(an), 32'h0000_000F);
        check_val({tag, "_seg"}, 32'(seg), 32'h0000_007F);
        check_val({tag, "_dp"}, 32'(dp), 32'h1);
        check_val({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        segs_a = {7'h79, 7'h24, 7'h30, 7'h19};  // 16'h1234
        segs_b = {7'h12, 7'h12, 7'h12, 7'h12};  // 16'h5555
        segs_c = {7'h7F, 7'h10, 7'h7F, 7'h03};  // 16'h89AB, digits 1/3 disabled
        segs_d = {7'h46, 7'h40, 7'h21, 7'h06};  // 16'hC0DE

        ARESETN    = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        disp_value = '0;
        dp_mask    = '0;
        digit_en   = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check_dark("reset");
        check_val("reset_load_ack", 32'(load_ack), 32'h0);

        // Basic scan of 1234, mid-frame double load, load on the boundary cycle, then enable
        // dropped during digit 2.
        ARESETN    = 1'b1;
        enable     = 1'b1;
        load       = 1'b1;
        disp_value = 16'h1234;
        dp_mask    = 4'h0;
        digit_en   = 4'hF;
        step();
        load = 1'b0;
        for (int c = 0; c <= 5 * FRAME + 2 * SLOT + 1; c++) begin
            logic ack_e;
            ack_e = (c == 0) || (c == 3 * FRAME) || (c == 4 * FRAME);
            if (c < 3 * FRAME)      scan_check(c, segs_a, 4'hF, 4'h0, ack_e);
            else if (c < 4 * FRAME) scan_check(c, segs_b, 4'hF, 4'h0, ack_e);
            else                    scan_check(c, segs_c, 4'b0101, 4'b0001, ack_e);
            load = 1'b0;
            if (c == 2 * FRAME + 1) begin
                load       = 1'b1;
                disp_value = 16'hAAAA;
            end
            if (c == 2 * FRAME + 7) begin
                load       = 1'b1;
                disp_value = 16'h5555;
            end
            if (c == 4 * FRAME - 1) begin
                load       = 1'b1;
                disp_value = 16'h89AB;
                digit_en   = 4'b0101;
                dp_mask    = 4'b0001;
            end
            if (c == 5 * FRAME + 2 * SLOT + 1) enable = 1'b0;
            step();
        end
        check_dark("disable");
        check_val("disable_load_ack", 32'(load_ack), 32'h0);
        step();
        check_dark("idle");

        // Load while idle applies on the next cycle
        load       = 1'b1;
        disp_value = 16'hC0DE;
        digit_en   = 4'hF;
        dp_mask    = 4'b0001;
        step();
        load = 1'b0;
        check_val("idle_load_ack", 32'(load_ack), 32'h1);
        check_dark("idle_load");
        step();
        check_val("idle_load_ack_clr", 32'(load_ack), 32'h0);

        // Re-enable restarts at digit 0; stage a load then reset mid-DRIVE
        enable = 1'b1;
        step();
        for (int c = 0; c <= SLOT + 1; c++) begin
            scan_check(c, segs_d, 4'hF, 4'b0001, 1'b0);
            load = 1'b0;
            if (c == 1) begin
                load       = 1'b1;
                disp_value = 16'hFFFF;
            end
            step();
        end
        #2;
        ARESETN = 1'b0;
        #1;
        check_dark("async_reset");
        check_val("async_reset_load_ack", 32'(load_ack), 32'h0);
        step();
        ARESETN = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            check_val($sformatf("post_reset_load_ack@%0d", i), 32'(load_ack), 32'h0);
            check_val($sformatf("post_reset_an@%0d", i), 32'(an), 32'h0000_000F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning ACLK cycles each digit is driven (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 16, meaning all-off cycles between digits (legal range 1..255).
REQ-003 SHALL have port ACLK, input, 1, meaning the single clock; all logic rising-edge.
REQ-004 SHALL have port ARESETN, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, meaning scanning runs while high.
REQ-006 SHALL have port load, input, 1, meaning one-cycle request to stage new display data.
REQ-007 SHALL have port disp_value, input, 16, meaning four hex nibbles; nibble k drives digit k.
REQ-008 SHALL have port dp_mask, input, 4, meaning per-digit decimal point on.
REQ-009 SHALL have port digit_en, input, 4, meaning per-digit enable; a disabled digit stays dark during its slot.
REQ-010 SHALL have port load_ack, output, 1, meaning one-cycle pulse when staged data becomes active.
REQ-011 SHALL have port seg, output, 7, meaning segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp, output, 1, meaning decimal point, active-low.
REQ-013 SHALL have port an, output, 4, meaning digit anodes, active-low, one-hot-low or all high.
REQ-014 SHALL have port frame_done, output, 1, meaning one-cycle pulse when digit index wraps 3->0.

Function
REQ-015 SHALL implement states IDLE, DRIVE, BLANK; IDLE->DRIVE(digit 0) when enable=1; DRIVE->BLANK after SCAN_DIV cycles; BLANK->DRIVE(next digit) after BLANK_CYC cycles.
REQ-016 SHALL return to IDLE from any state within one cycle of enable=0, resetting digit index and counters to 0.
REQ-017 SHALL, in IDLE and BLANK, drive an=4'hF, seg=7'h7F, dp=1.
REQ-018 SHALL, in DRIVE for digit k with digit_en[k]=1 (active register), drive an[k]=0, seg=hex decode of nibble k, dp=~dp_mask[k]; with digit_en[k]=0, an=4'hF.
REQ-019 SHALL decode 0-F to standard segments (e.g. 0->7'h40, 8->7'h00, F->7'h0E active-low).
REQ-020 SHALL register outputs; an/seg/dp change only on state or digit transitions, never glitch mid-slot.
REQ-021 SHALL capture disp_value, dp_mask, digit_en into a pending register on load=1; later loads before application overwrite (last wins).
REQ-022 SHALL copy pending to active at the frame boundary (BLANK after digit 3 -> DRIVE digit 0) and pulse load_ack in that same cycle; a load coinciding with the boundary cycle is applied at that boundary.
REQ-023 SHALL, when load occurs in IDLE, apply it immediately on the next cycle with load_ack.
REQ-024 SHALL pulse frame_done for exactly one cycle at each 3->0 wrap, coincident with any load_ack.
REQ-025 SHALL size counters to $clog2(SCAN_DIV) and 8 bits; counters wrap only by state transition, never overflow.

Reset
REQ-026 SHALL, on ARESETN=0, asynchronously force state=IDLE, digit index=0, counters=0, pending and active registers=0, pending-valid=0, an=4'hF, seg=7'h7F, dp=1, load_ack=0, frame_done=0.
REQ-027 SHALL, on reset mid-frame, discard pending data with no load_ack and resume from IDLE after release.

Configuration
REQ-028 SHALL honour macro FND_BLANK_EN: defined -> BLANK state inserted per REQ-015; undefined -> BLANK omitted, DRIVE->DRIVE(next digit) directly, BLANK_CYC ignored, frame boundary at DRIVE digit 3 end.

Verification (SCAN_DIV=4, BLANK_CYC=2, FND_BLANK_EN defined unless noted)
REQ-029 SHALL cover: reset then enable=1, load 16'h1234, dp_mask=0, digit_en=F -> load_ack next cycle; an sequence E,F,D,F,B,F,7,F; seg 7'h79,7'h24,7'h30,7'h19; 4/2-cycle slots; frame_done every 24 cycles.
REQ-030 SHALL cover: mid-frame loads 16'hAAAA then 16'h5555 -> single load_ack at boundary, digits show 5 from next frame.
REQ-031 SHALL cover: digit_en=4'b0101, dp_mask=4'b0001 -> an stays F in slots 1 and 3; dp=0 only in slot 0.
REQ-032 SHALL cover: enable dropped during digit 2 -> an=F, seg=7F next cycle; re-enable restarts at digit 0.
REQ-033 SHALL cover: ARESETN asserted mid-DRIVE with pending load -> outputs dark immediately; no load_ack after release.
REQ-034 SHALL cover: FND_BLANK_EN undefined -> an sequence E,D,B,7 with no F slots; frame_done every 16 cycles.
